mmu_dcache_req_arbiter: RTL
===========================

Name: mmu_dcache_req_arbiter

Overview:
- Shares the single E1 data-cache request port of the MMU between two requesters:
  - port 0: the processor load/store unit.
  - port 1: the cache-maintenance/prefetch engine (DINVAL, WPURGE, DTOUCHL).
- Fixed priority to port 0, with an anti-starvation counter for port 1.
- Holds the presented request stable until the dcache grants it.
- Tracks the owner of the access in E2 so that E2 trap outcomes are routed back to the requester that issued the access.

Parameters:
- ADDR_W, 41, virtual address width.
- STARVE_MAX, 4, number of consecutive port-0 wins while port 1 is waiting before port 1 is forced; range 1..15.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pN_req_i  in  1  request from port N (N = 0, 1).
- pN_virt_addr_i  in  ADDR_W  virtual address.
- pN_opc_i  in  6  dcache opcode (e1_dcache_opc_t encoding).
- pN_size_i  in  4  access size.
- pN_glob_acc_i  in  1  global access.
- pN_non_trapping_i  in  1  non-trapping access.
- pN_grant_o  out  1  request accepted this cycle.
- pN_e2_valid_o  out  1  E2 result for port N is valid this cycle.
- pN_e2_trap_o  out  11  trap vector for port N.
- dc_req_o  out  1  request to the dcache.
- dc_virt_addr_o, dc_opc_o, dc_size_o, dc_glob_acc_o, dc_non_trapping_o  out  per width  muxed payload.
- dc_grant_i  in  1  dcache E1 grant.
- e2_stall_i  in  1  E2 stall from the MMU.
- e2_trap_i  in  11  {nomapping[1:0], protection[1:0], writetoclean[1:0], atomictoclean[1:0], dmisalign, dsyserror[1:0]}.
- proto_err_o  out  1  sticky protocol error.
- stat_grant0_o, stat_grant1_o  out  16  grant counters (optional feature).

Behaviour:
- Reset: every register is cleared.
  - FSM goes to IDLE.
  - sel = 0, starve_cnt = 0, e2_valid = 0, proto_err_o = 0.
  - All outputs are 0.
- FSM states are IDLE and LOCK.
- IDLE:
  - Arbitration is combinational:
    - only one port requesting: that port wins;
    - both requesting: port 0 wins unless starve_cnt == STARVE_MAX, in which case port 1 wins.
  - dc_req_o = p0_req_i | p1_req_i; the payload is muxed from the winner.
  - If there is no dc_grant_i and a request is present: register sel = winner and go to LOCK.
- LOCK:
  - sel is frozen; dc_req_o = p[sel]_req_i; the payload comes from port sel.
  - dc_grant_i returns the FSM to IDLE.
- Grant:
  - pN_grant_o = dc_grant_i & dc_req_o & (the effective selection == N).
  - Grant has zero-cycle latency, so a single-cycle transaction is possible in IDLE.
- starve_cnt: updated only on an accepted request (dc_req_o & dc_grant_i).
  - Port 0 accepted while p1_req_i = 1: increment, saturating at STARVE_MAX.
  - Port 1 accepted: clear to 0.
  - Otherwise: hold.
- E2 tracking:
  - On an accepted request, the next cycle has e2_valid = 1 and e2_owner = winner.
  - While e2_stall_i = 1, the E2 stage holds.
  - The stage clears when !e2_stall_i and there is no new accept.
  - A new accept while e2_stall_i = 1 and e2_valid = 1: set proto_err_o; the new access overwrites the stage.
- Results:
  - pN_e2_valid_o = e2_valid & !e2_stall_i & (e2_owner == N).
  - pN_e2_trap_o = pN_e2_valid_o ? e2_trap_i : 0.
- Protocol violation: p[sel]_req_i falls while in LOCK.
  - Set proto_err_o (sticky until reset).
  - Return to IDLE; dc_req_o is 0 that cycle.
- Reset mid-operation:
  - A LOCK request is dropped and the E2 owner is discarded.
  - No grant or valid is emitted in the reset cycle.

Optional Feature:
- Macro: MMU_DCACHE_ARB_STATS_EN.
- Defined:
  - stat_grant0_o and stat_grant1_o count accepted requests per port.
  - The counters are 16 bits, saturate at 0xFFFF and clear on reset.
- Not defined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Single port 0 LOAD, addr 0x1_0000_0040, dc_grant_i = 1 in the same cycle -> p0_grant_o = 1 in cycle 0; p0_e2_valid_o = 1 in cycle 1 with e2_trap_i = 0x000 echoed; p1 outputs stay 0.
- Both ports request continuously, dc_grant_i = 1 every cycle, STARVE_MAX = 4 -> grant sequence p0, p0, p0, p0, p1, p0, ...; starve_cnt returns to 0 after the p1 grant.
- Port 1 DINVAL with no grant for 3 cycles while port 0 asserts from cycle 1 -> dc_* payload stays port 1's for all 3 cycles; p1_grant_o on cycle 3; p0 is granted afterwards.
- Accept port 0 with e2_stall_i = 1 for 2 cycles and e2_trap_i = 0x004 (dmisalign) -> p0_e2_valid_o = 0 for 2 cycles, then 1 with p0_e2_trap_o = 0x004; p1_e2_trap_o = 0.
- Port 1 drops its request while in LOCK -> proto_err_o = 1 the next cycle and stays 1; FSM is in IDLE. Then assert reset for one cycle -> proto_err_o = 0 and all outputs are 0.
- With MMU_DCACHE_ARB_STATS_EN: 10 p0 and 3 p1 accepts -> stat_grant0_o = 10, stat_grant1_o = 3. Without the macro: both read 0.

Source files
------------

// File: rtl/mmu_dcache_req_arbiter_if.sv
// Bundle between the two dcache requesters, the arbiter and the E1/E2 dcache port.
// Handshake: a request is accepted in the cycle where dc_req & dc_grant; a requester keeps req and payload stable until its grant.
interface mmu_dcache_req_arbiter_if #(
   parameter int ADDR_W = 41
);
   logic              p0_req;
   logic [ADDR_W-1:0] p0_virt_addr;
   logic [5:0]        p0_opc;
   logic [3:0]        p0_size;
   logic              p0_glob_acc;
   logic              p0_non_trapping;
   logic              p0_grant;
   logic              p0_e2_valid;
   logic [10:0]       p0_e2_trap;

   logic              p1_req;
   logic [ADDR_W-1:0] p1_virt_addr;
   logic [5:0]        p1_opc;
   logic [3:0]        p1_size;
   logic              p1_glob_acc;
   logic              p1_non_trapping;
   logic              p1_grant;
   logic              p1_e2_valid;
   logic [10:0]       p1_e2_trap;

   logic              dc_req;
   logic [ADDR_W-1:0] dc_virt_addr;
   logic [5:0]        dc_opc;
   logic [3:0]        dc_size;
   logic              dc_glob_acc;
   logic              dc_non_trapping;
   logic              dc_grant;
   logic              e2_stall;
   logic [10:0]       e2_trap;

   logic              proto_err;
   logic [15:0]       stat_grant0;
   logic [15:0]       stat_grant1;

   // Requester/dcache side of the bundle.
   modport master (
      output p0_req, p0_virt_addr, p0_opc, p0_size, p0_glob_acc, p0_non_trapping,
      output p1_req, p1_virt_addr, p1_opc, p1_size, p1_glob_acc, p1_non_trapping,
      output dc_grant, e2_stall, e2_trap,
      input  p0_grant, p0_e2_valid, p0_e2_trap, p1_grant, p1_e2_valid, p1_e2_trap,
      input  dc_req, dc_virt_addr, dc_opc, dc_size, dc_glob_acc, dc_non_trapping,
      input  proto_err, stat_grant0, stat_grant1
   );

   // Arbiter side of the bundle.
   modport slave (
      input  p0_req, p0_virt_addr, p0_opc, p0_size, p0_glob_acc, p0_non_trapping,
      input  p1_req, p1_virt_addr, p1_opc, p1_size, p1_glob_acc, p1_non_trapping,
      input  dc_grant, e2_stall, e2_trap,
      output p0_grant, p0_e2_valid, p0_e2_trap, p1_grant, p1_e2_valid, p1_e2_trap,
      output dc_req, dc_virt_addr, dc_opc, dc_size, dc_glob_acc, dc_non_trapping,
      output proto_err, stat_grant0, stat_grant1
   );
endinterface

// File: rtl/mmu_dcache_req_arbiter.sv
// Two-port arbiter for the MMU E1 dcache request port with E2 result routing.
// Optional per-port grant counters: define MMU_DCACHE_ARB_STATS_EN.
module mmu_dcache_req_arbiter #(
   parameter int ADDR_W     = 41,
   parameter int STARVE_MAX = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   mmu_dcache_req_arbiter_if.slave  bus,
   output logic [0:0]               fsm_state
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [0:0]        state;
   logic              sel;
   logic [3:0]        starve_cnt;
   logic              e2_valid;
   logic              e2_owner;
   logic              proto_err;

   logic              winner;
   logic              eff_sel;
   logic              sel_req;
   logic              dc_req;
   logic              accept;
   logic              lock_drop;
   logic [ADDR_W-1:0] addr_mux;

   always_comb begin
      if (bus.p0_req && bus.p1_req) begin
         winner = (starve_cnt == STARVE_LIM);
      end else begin
         winner = bus.p1_req;
      end
      eff_sel   = (state == LOCK) ? sel : winner;
      sel_req   = sel ? bus.p1_req : bus.p0_req;
      lock_drop = (state == LOCK) && !sel_req;
      // Reset gates the request so nothing is granted in the reset cycle.
      if (reset) begin
         dc_req = 1'b0;
      end else if (state == LOCK) begin
         dc_req = sel_req;
      end else begin
         dc_req = bus.p0_req | bus.p1_req;
      end
      accept   = dc_req & bus.dc_grant;
      addr_mux = eff_sel ? bus.p1_virt_addr : bus.p0_virt_addr;
   end

   assign bus.dc_req          = dc_req;
   assign bus.dc_virt_addr    = dc_req ? addr_mux : '0;
   assign bus.dc_opc          = !dc_req ? 6'd0 : (eff_sel ? bus.p1_opc : bus.p0_opc);
   assign bus.dc_size         = !dc_req ? 4'd0 : (eff_sel ? bus.p1_size : bus.p0_size);
   assign bus.dc_glob_acc     = dc_req & (eff_sel ? bus.p1_glob_acc : bus.p0_glob_acc);
   assign bus.dc_non_trapping = dc_req & (eff_sel ? bus.p1_non_trapping : bus.p0_non_trapping);

   assign bus.p0_grant    = accept & !eff_sel;
   assign bus.p1_grant    = accept & eff_sel;
   assign bus.p0_e2_valid = e2_valid & !bus.e2_stall & !e2_owner & !reset;
   assign bus.p1_e2_valid = e2_valid & !bus.e2_stall & e2_owner & !reset;
   assign bus.p0_e2_trap  = bus.p0_e2_valid ? bus.e2_trap : 11'd0;
   assign bus.p1_e2_trap  = bus.p1_e2_valid ? bus.e2_trap : 11'd0;
   assign bus.proto_err   = proto_err;
   assign fsm_state       = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         sel        <= 1'b0;
         starve_cnt <= 4'd0;
         e2_valid   <= 1'b0;
         e2_owner   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dc_req && !bus.dc_grant) begin
                  state <= LOCK;
                  sel   <= winner;
               end
            end
            default: begin
               if (lock_drop) begin
                  proto_err <= 1'b1;
                  state     <= IDLE;
               end else if (bus.dc_grant) begin
                  state <= IDLE;
               end
            end
         endcase

         if (accept) begin
            if (eff_sel) begin
               starve_cnt <= 4'd0;
            end else if (bus.p1_req && (starve_cnt < STARVE_LIM)) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end

         // A stalled E2 access overwritten by a new accept is a protocol error.
         if (accept) begin
            e2_valid <= 1'b1;
            e2_owner <= eff_sel;
            if (bus.e2_stall && e2_valid) begin
               proto_err <= 1'b1;
            end
         end else if (!bus.e2_stall) begin
            e2_valid <= 1'b0;
         end
      end
   end

`ifdef MMU_DCACHE_ARB_STATS_EN
   logic [15:0] stat0;
   logic [15:0] stat1;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat0 <= 16'd0;
         stat1 <= 16'd0;
      end else begin
         if (accept && !eff_sel && (stat0 != 16'hFFFF)) begin
            stat0 <= stat0 + 16'd1;
         end
         if (accept && eff_sel && (stat1 != 16'hFFFF)) begin
            stat1 <= stat1 + 16'd1;
         end
      end
   end

   assign bus.stat_grant0 = stat0;
   assign bus.stat_grant1 = stat1;
`else
   assign bus.stat_grant0 = 16'd0;
   assign bus.stat_grant1 = 16'd0;
`endif
endmodule
